program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer-side counterpart to the CPU's instruction fetch path.
- Receives a byte stream through a valid/ready handshake and assembles it into 32-bit instruction words, most significant byte first.
- Writes the words into the 16x32 instruction RAM over the shared address/data bus, then releases the CPU from hold.
- Sits between an external byte source (UART/host bridge) and the RAM address-bus mux; it owns the bus while loading.

Parameters:
DEPTH, 16, number of RAM words; valid word counts are 1..DEPTH
ADDR_W, 16, RAM address bus width
BASE_ADDR, 0, RAM address of the first loaded word

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
start  input  1  single-cycle pulse that begins a load session
byte_valid  input  1  source presents a byte
byte_data  input  8  byte payload
byte_ready  output  1  loader accepts byte this cycle; a transfer occurs when byte_valid && byte_ready
mem_sel  output  1  high = loader drives the RAM address/data bus
mem_we  output  1  RAM write strobe, one cycle per word
mem_addr  output  ADDR_W  RAM word address
mem_wdata  output  32  RAM write data
cpu_hold  output  1  high = CPU held in its LOAD state
load_done  output  1  session completed with a good checksum
load_error  output  1  session aborted (bad count or checksum mismatch)

Behaviour:
- Reset (clk edge with rst=0), applied from any state, including mid-session:
  - state IDLE, byte_ready=0, mem_sel=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_error=0.
  - Internal word index, byte counter and checksum are cleared.
- Stream format: COUNT byte N, then N×4 data bytes (MSB first per word), then one checksum byte. The checksum is the XOR of all 4N data bytes; the COUNT byte is excluded.
- States: IDLE, COUNT, ASSEMBLE, WRITE, CHECK, DONE, ERROR.
- IDLE:
  - byte_ready=0.
  - start=1 → COUNT next cycle; load_done and load_error cleared; cpu_hold=1; index=0; checksum=0.
- COUNT:
  - byte_ready=1, mem_sel=1.
  - On transfer: if 1≤byte_data≤DEPTH, latch N and go to ASSEMBLE. Otherwise go to ERROR.
- ASSEMBLE:
  - byte_ready=1, mem_sel=1.
  - Each transfer shifts the byte into a 32-bit word at [31:24], [23:16], [15:8], [7:0] in order.
  - Each transfer XORs the byte into the checksum.
  - The 4th byte transfer → WRITE next cycle.
- WRITE (exactly 1 cycle):
  - byte_ready=0, mem_sel=1, mem_we=1, mem_addr=BASE_ADDR+index, mem_wdata=assembled word.
  - Next cycle: index+1. If the new index equals N → CHECK, else → ASSEMBLE.
  - mem_we=0 in every other state.
- CHECK:
  - byte_ready=1, mem_sel=1.
  - On transfer: byte equals checksum → DONE, else → ERROR.
- DONE:
  - load_done=1, cpu_hold=0, mem_sel=0, byte_ready=0.
  - Held until start or reset; start → COUNT, which reloads and re-asserts cpu_hold.
- ERROR:
  - load_error=1, cpu_hold=1, mem_sel=0, byte_ready=0.
  - RAM words already written are not reverted.
  - start → COUNT.
- Ignored inputs:
  - start is ignored in COUNT, ASSEMBLE, WRITE and CHECK.
  - byte_valid while byte_ready=0 is ignored; no byte is consumed.
- Stalls: byte_valid may drop for any number of cycles mid-word; partial word and counters hold.
- Throughput: the maximum rate is one word per 5 cycles (4 accepts + 1 write).
- mem_addr retains its last written value outside WRITE. Address arithmetic is modulo 2^ADDR_W.
- All outputs are registered, except byte_ready, which is decoded from the state register only (never from byte_valid).

Test Plan:
- Reset then start, stream N=2, words 0xE1A00000 and 0x12345678, checksum 0xE1^0xA0^0^0^0x12^0x34^0x56^0x78 → mem_we pulses at addr 0 and 1 with those data, load_done=1, cpu_hold=0.
- Count byte 0x00, then a separate session with count 0x11 → load_error=1, cpu_hold=1, no mem_we pulse.
- N=1, word 0xDEADBEEF, checksum 0x00 (wrong; correct is 0x22) → word written at addr 0, load_error=1, load_done=0.
- N=16 with byte_valid toggling every other cycle → 16 writes to addresses 0..15, correct order, no lost or duplicated bytes, load_done=1.
- Reset asserted after 2 bytes of word 3 → all outputs at reset values; a fresh session loads correctly from addr 0.
- start pulsed during ASSEMBLE → ignored. start in DONE → cpu_hold returns to 1 and a new N=1 load overwrites addr 0.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: takes COUNT, N*4 data bytes (MSB first) and an XOR checksum,
// writes the assembled words into instruction RAM and releases the CPU on success.
module program_loader #(
  parameter int unsigned       DEPTH     = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  // Wide enough to hold the word count DEPTH itself, not just DEPTH-1.
  localparam int unsigned IdxW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StAssemble,
    StWrite,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [IdxW-1:0]   n_q;
  logic [1:0]        bcnt_q;
  logic [7:0]        csum_q;
  logic [23:0]       word_q;
  logic              mem_sel_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_hold_q;
  logic              load_done_q;
  logic              load_error_q;

  logic            xfer;
  logic            count_ok;
  logic [IdxW-1:0] idx_inc;

  assign xfer     = byte_valid && byte_ready;
  assign count_ok = (byte_data != 8'd0) && (32'(byte_data) <= DEPTH);
  assign idx_inc  = idx_q + IdxW'(1);

  // Ready depends on the state register only, never on byte_valid.
  always_comb begin
    byte_ready = 1'b0;
    unique case (state_q)
      StCount, StAssemble, StCheck: byte_ready = 1'b1;
      default:                      byte_ready = 1'b0;
    endcase
  end

  // Session FSM; outputs are registered alongside each state transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      n_q          <= '0;
      bcnt_q       <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      mem_sel_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_q      <= StCount;
            idx_q        <= '0;
            bcnt_q       <= '0;
            csum_q       <= '0;
            mem_sel_q    <= 1'b1;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
          end
        end
        StCount: begin
          if (xfer) begin
            if (count_ok) begin
              n_q     <= IdxW'(byte_data);
              bcnt_q  <= '0;
              state_q <= StAssemble;
            end else begin
              mem_sel_q    <= 1'b0;
              load_error_q <= 1'b1;
              state_q      <= StError;
            end
          end
        end
        StAssemble: begin
          if (xfer) begin
            word_q <= {word_q[15:0], byte_data};
            csum_q <= csum_q ^ byte_data;
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= BASE_ADDR + ADDR_W'(idx_q);
              mem_wdata_q <= {word_q, byte_data};
              state_q     <= StWrite;
            end
          end
        end
        StWrite: begin
          mem_we_q <= 1'b0;
          idx_q    <= idx_inc;
          bcnt_q   <= '0;
          state_q  <= (idx_inc == n_q) ? StCheck : StAssemble;
        end
        StCheck: begin
          if (xfer) begin
            mem_sel_q <= 1'b0;
            if (byte_data == csum_q) begin
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
              state_q     <= StDone;
            end else begin
              load_error_q <= 1'b1;
              state_q      <= StError;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_sel    = mem_sel_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of load sessions plus hand-written corner sequences.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_sel;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  always #5 clk = ~clk;

  program_loader #(
    .DEPTH    (16),
    .ADDR_W   (16),
    .BASE_ADDR(16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_sel   (mem_sel),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wbuf[16];
  logic [47:0] wq[$];

  // Record every RAM write as {addr, data}.
  always @(negedge clk) if (mem_we) wq.push_back({mem_addr, mem_wdata});

  typedef struct {
    logic [7:0]  cnt;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  cs;
    bit          exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_accept_timeout: byte %h never accepted", b);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [7:0] csum(input int nw);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < nw; i++) c = c ^ wbuf[i][31:24] ^ wbuf[i][23:16] ^ wbuf[i][15:8] ^ wbuf[i][7:0];
    return c;
  endfunction

  // Count byte, nw words from wbuf, then the checksum byte when any words were sent.
  task automatic run_body(input logic [7:0] cnt, input int nw, input logic [7:0] cs, input int gap);
    wq.delete();
    send_byte(cnt, gap);
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < 4; k++) send_byte(wbuf[i][31-8*k -: 8], gap);
    if (nw > 0) send_byte(cs, gap);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_load(input logic [7:0] cnt, input int nw, input logic [7:0] cs, input int gap);
    pulse_start();
    run_body(cnt, nw, cs, gap);
  endtask

  task automatic check_end(input string tag, input bit exp_done, input int nw);
    chk({tag, "_done"}, 48'(load_done), 48'(exp_done));
    chk({tag, "_error"}, 48'(load_error), 48'(!exp_done));
    chk({tag, "_hold"}, 48'(cpu_hold), 48'(!exp_done));
    chk({tag, "_sel"}, 48'(mem_sel), 48'(0));
    chk({tag, "_ready"}, 48'(byte_ready), 48'(0));
    chk({tag, "_nwrites"}, 48'(wq.size()), 48'(nw));
    for (int i = 0; i < nw && i < wq.size(); i++)
      chk({tag, "_write"}, wq[i], {16'(i), wbuf[i]});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, 48'(byte_ready), 48'(0));
    chk({tag, "_sel"}, 48'(mem_sel), 48'(0));
    chk({tag, "_we"}, 48'(mem_we), 48'(0));
    chk({tag, "_addr"}, 48'(mem_addr), 48'(0));
    chk({tag, "_wdata"}, 48'(mem_wdata), 48'(0));
    chk({tag, "_hold"}, 48'(cpu_hold), 48'(1));
    chk({tag, "_done"}, 48'(load_done), 48'(0));
    chk({tag, "_error"}, 48'(load_error), 48'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Checksums hand-computed: E1^A0^12^34^56^78 = 49, DE^AD^BE^EF = 22.
    vecs[0] = '{8'd2,  2, 32'hE1A0_0000, 32'h1234_5678, 8'h49, 1'b1};
    vecs[1] = '{8'h00, 0, 32'h0,         32'h0,         8'h00, 1'b0};
    vecs[2] = '{8'h11, 0, 32'h0,         32'h0,         8'h00, 1'b0};
    vecs[3] = '{8'd1,  1, 32'hDEAD_BEEF, 32'h0,         8'h00, 1'b0};
    vecs[4] = '{8'd1,  1, 32'hDEAD_BEEF, 32'h0,         8'h22, 1'b1};

    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      wbuf[0] = vecs[v].w0;
      wbuf[1] = vecs[v].w1;
      run_load(vecs[v].cnt, vecs[v].nw, vecs[v].cs, 0);
      check_end($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].nw);
      if (v == 0) begin
        chk("addr_retained", 48'(mem_addr), 48'(1));
        // Valid while not ready must not consume anything in DONE.
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        chk("idle_valid_done", 48'(load_done), 48'(1));
        chk("idle_valid_ready", 48'(byte_ready), 48'(0));
      end
    end

    // Full depth with a bubble after every byte.
    for (int i = 0; i < 16; i++)
      wbuf[i] = {8'(i), 8'(8'hF0 ^ i), 8'(i * 7), 8'(8'hA5 + i)};
    run_load(8'd16, 16, csum(16), 1);
    check_end("n16", 1'b1, 16);

    // Reset after two bytes of the third word.
    wq.delete();
    pulse_start();
    send_byte(8'd4, 0);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) send_byte(wbuf[i][31-8*k -: 8], 0);
    send_byte(wbuf[2][31:24], 0);
    send_byte(wbuf[2][23:16], 0);
    chk("pre_rst_nwrites", 48'(wq.size()), 48'(2));
    rst = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b1;
    @(negedge clk);
    wbuf[0] = 32'hCAFE_F00D;
    run_load(8'd1, 1, csum(1), 0);
    check_end("after_rst", 1'b1, 1);

    // start during ASSEMBLE is ignored.
    wbuf[0] = 32'h0BAD_C0DE;
    wq.delete();
    pulse_start();
    send_byte(8'd1, 0);
    send_byte(8'h0B, 0);
    send_byte(8'hAD, 0);
    pulse_start();
    send_byte(8'hC0, 0);
    send_byte(8'hDE, 0);
    send_byte(8'h0B ^ 8'hAD ^ 8'hC0 ^ 8'hDE, 0);
    repeat (2) @(negedge clk);
    check_end("start_in_asm", 1'b1, 1);

    // start in DONE re-holds the CPU and reloads address 0.
    pulse_start();
    chk("reload_hold", 48'(cpu_hold), 48'(1));
    chk("reload_done", 48'(load_done), 48'(0));
    chk("reload_ready", 48'(byte_ready), 48'(1));
    chk("reload_sel", 48'(mem_sel), 48'(1));
    wbuf[0] = 32'h7654_3210;
    run_body(8'd1, 1, csum(1), 0);
    check_end("reload", 1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
